// File: rtl/counter_checker.sv
// -----------------------------------------------------------------------------
// counter_checker
//
// Watches the output of an 8-bit free-running up-counter and confirms that
// every qualified sample is exactly one more (mod 256) than the previous one.
// After LOCK_N consecutive correct increments the checker declares lock; a
// broken sequence while locked raises a one-cycle err pulse and is counted.
//
// Configuration macro: COUNTER_CHK_RESYNC_EN
//   undefined : a mismatch in LOCKED parks the checker in FAULT until reset.
//   defined   : a mismatch in LOCKED drops back to ACQ to re-acquire lock;
//               FAULT is never entered and fault is tied low.
//
// Parameters
//   LOCK_N    consecutive correct increments needed to lock (1..15)
//
// Ports
//   clk       rising-edge clock
//   res       asynchronous active-low reset
//   en        sample qualifier; din is ignored when low
//   din       [7:0] observed counter value
//   locked    high while in LOCKED
//   err       one-cycle pulse, one clock after a mismatching sample in LOCKED
//   fault     high while in FAULT
//   err_cnt   [7:0] mismatches detected in LOCKED, saturating at 255
//   wrap_cnt  [7:0] correct 255->0 wraps seen in LOCKED, saturating at 255
// -----------------------------------------------------------------------------
module counter_checker #(
   parameter int LOCK_N = 4
) (
   input  logic       clk,
   input  logic       res,
   input  logic       en,
   input  logic [7:0] din,
   output logic       locked,
   output logic       err,
   output logic       fault,
   output logic [7:0] err_cnt,
   output logic [7:0] wrap_cnt
);

   typedef enum logic [1:0] {
      s_idle   = 2'd0,
      s_acq    = 2'd1,
      s_locked = 2'd2,
      s_fault  = 2'd3
   } state_t;

   localparam logic [3:0] lock_n_l = 4'(LOCK_N);

   state_t     state,    state_nxt;
   logic [7:0] exp_val,  exp_nxt;
   logic [3:0] good,     good_nxt;
   logic       err_nxt;
   logic [7:0] err_cnt_nxt;
   logic [7:0] wrap_cnt_nxt;
   logic       match;

   assign match = (din == exp_val);

   // --------------------------------------------------------------------------
   // Next-state and next-output logic
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default before any branch so no path leaves
      // it unassigned; that is what keeps this block from inferring latches.
      state_nxt    = state;
      exp_nxt      = exp_val;
      good_nxt     = good;
      err_nxt      = 1'b0;
      err_cnt_nxt  = err_cnt;
      wrap_cnt_nxt = wrap_cnt;

      if (en) begin
         // Every qualified sample re-aligns the expectation to what was seen,
         // so a single glitch costs exactly one mismatch, not a cascade.
         exp_nxt = din + 8'd1;

         unique case (state)
            s_idle: begin
               good_nxt  = 4'd0;
               state_nxt = s_acq;
            end

            s_acq: begin
               if (match) begin
                  // good never exceeds LOCK_N-1 here, so the +1 cannot wrap.
                  if (good + 4'd1 == lock_n_l) begin
                     good_nxt  = 4'd0;
                     state_nxt = s_locked;
                  end else begin
                     good_nxt = good + 4'd1;
                  end
               end else begin
                  // Acquisition misses are expected noise: no err, no count.
                  good_nxt = 4'd0;
               end
            end

            s_locked: begin
               if (match) begin
                  if (din == 8'd0 && wrap_cnt != 8'hff)
                     wrap_cnt_nxt = wrap_cnt + 8'd1;
               end else begin
                  err_nxt = 1'b1;
                  if (err_cnt != 8'hff)
                     err_cnt_nxt = err_cnt + 8'd1;
`ifdef COUNTER_CHK_RESYNC_EN
                  good_nxt  = 4'd0;
                  state_nxt = s_acq;
`else
                  state_nxt = s_fault;
`endif
               end
            end

            s_fault: begin
               // Sticky: only reset leaves FAULT; counters hold.
               state_nxt = s_fault;
            end

            default: state_nxt = s_idle;
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // State and output registers
   // --------------------------------------------------------------------------
   // locked/fault are decoded from the next state and registered alongside the
   // state itself, so they change on the same edge as the state register.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         // NOTE: every register, including the counters, is cleared by reset;
         // the reset drops any err pulse in flight along with all history.
         state    <= s_idle;
         exp_val  <= 8'd0;
         good     <= 4'd0;
         err      <= 1'b0;
         err_cnt  <= 8'd0;
         wrap_cnt <= 8'd0;
         locked   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values computed by the combinational block above.
         state    <= state_nxt;
         exp_val  <= exp_nxt;
         good     <= good_nxt;
         err      <= err_nxt;
         err_cnt  <= err_cnt_nxt;
         wrap_cnt <= wrap_cnt_nxt;
         locked   <= (state_nxt == s_locked);
      end
   end

`ifdef COUNTER_CHK_RESYNC_EN
   // FAULT is unreachable in this build.
   assign fault = 1'b0;
`else
   always_ff @(posedge clk or negedge res) begin
      if (!res)
         fault <= 1'b0;
      else
         fault <= (state_nxt == s_fault);
   end
`endif

endmodule

// File: tb/tb_counter_checker.sv
// -----------------------------------------------------------------------------
// tb_counter_checker
//
// Directed bench for counter_checker (LOCK_N = 4). Each step drives one
// sample on the falling edge and pushes the outputs expected after the next
// rising edge onto a scoreboard queue; the entry is popped and compared one
// time unit after that rising edge. Expectations follow the build selected by
// COUNTER_CHK_RESYNC_EN.
// -----------------------------------------------------------------------------
module tb_counter_checker;

   typedef struct {
      string      tag;
      logic       locked;
      logic       err;
      logic       fault;
      logic [7:0] err_cnt;
      logic [7:0] wrap_cnt;
   } exp_t;

`ifdef COUNTER_CHK_RESYNC_EN
   localparam bit resync = 1'b1;
`else
   localparam bit resync = 1'b0;
`endif

   logic       clk;
   logic       res;
   logic       en;
   logic [7:0] din;
   logic       locked;
   logic       err;
   logic       fault;
   logic [7:0] err_cnt;
   logic [7:0] wrap_cnt;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   counter_checker #(.LOCK_N(4)) dut (
      .clk      (clk),
      .res      (res),
      .en       (en),
      .din      (din),
      .locked   (locked),
      .err      (err),
      .fault    (fault),
      .err_cnt  (err_cnt),
      .wrap_cnt (wrap_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic push(input string tag, input logic l, input logic e, input logic f,
                       input logic [7:0] ec, input logic [7:0] wc);
      exp_t x;
      x.tag = tag; x.locked = l; x.err = e; x.fault = f; x.err_cnt = ec; x.wrap_cnt = wc;
      sb.push_back(x);
   endtask

   task automatic pop_compare();
      exp_t x;
      if (sb.size() == 0) begin
         check("scoreboard_empty", 8'd1, 8'd0);
         return;
      end
      x = sb.pop_front();
      check({x.tag, ".locked"},   {7'd0, locked}, {7'd0, x.locked});
      check({x.tag, ".err"},      {7'd0, err},    {7'd0, x.err});
      check({x.tag, ".fault"},    {7'd0, fault},  {7'd0, x.fault});
      check({x.tag, ".err_cnt"},  err_cnt,        x.err_cnt);
      check({x.tag, ".wrap_cnt"}, wrap_cnt,       x.wrap_cnt);
   endtask

   // One sample: drive on negedge, expectation queued, compare after posedge.
   task automatic step(input string tag, input logic e, input logic [7:0] d,
                       input logic l, input logic er, input logic f,
                       input logic [7:0] ec, input logic [7:0] wc);
      @(negedge clk);
      en  = e;
      din = d;
      push(tag, l, er, f, ec, wc);
      @(posedge clk);
      #1;
      pop_compare();
   endtask

   // Asynchronous reset pulse placed between clock edges; outputs must clear
   // before the next rising edge.
   task automatic async_reset(input string tag);
      @(posedge clk);
      #3;
      res = 1'b0;
      #1;
      push(tag, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      pop_compare();
      @(negedge clk);
      en  = 1'b0;
      res = 1'b1;
   endtask

   initial begin
      res = 1'b0;
      en  = 1'b0;
      din = 8'd0;

      // Reset state.
      #2;
      push("reset", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      pop_compare();
      repeat (2) @(posedge clk);
      @(negedge clk);
      res = 1'b1;

      // en low in IDLE does nothing.
      step("idle_en0", 1'b0, 8'd77, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);

      // Acquire: 0 enters ACQ, 1..4 are four good increments -> locked.
      step("acq_d0", 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      step("acq_d1", 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      step("acq_d2", 1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      step("acq_d3", 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      step("lock_d4", 1'b1, 8'd4, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);

      // en gating while locked: the unqualified 99 is ignored.
      step("en_d5",   1'b1, 8'd5,  1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
      step("en0_d99", 1'b0, 8'd99, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
      step("en_d6",   1'b1, 8'd6,  1'b1, 1'b0, 1'b0, 8'd0, 8'd0);

      for (int v = 7; v <= 11; v++)
         step("run", 1'b1, 8'(v), 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);

      // Mismatch 11 -> 20: err pulse one clock later, counted once.
      step("mis_d20", 1'b1, 8'd20, 1'b0, 1'b1, !resync, 8'd1, 8'd0);
      step("post_d21", 1'b1, 8'd21, 1'b0, 1'b0, !resync, 8'd1, 8'd0);
      step("post_d22", 1'b1, 8'd22, 1'b0, 1'b0, !resync, 8'd1, 8'd0);
      step("post_d23", 1'b1, 8'd23, 1'b0, 1'b0, !resync, 8'd1, 8'd0);
      // Resync build re-locks after 21..24; default build stays in FAULT.
      step("post_d24", 1'b1, 8'd24, resync, 1'b0, !resync, 8'd1, 8'd0);
      // Another break: counted only when locked (resync); FAULT ignores it.
      step("post_d99", 1'b1, 8'd99, 1'b0, resync, !resync,
           resync ? 8'd2 : 8'd1, 8'd0);

      // Reset between edges clears everything immediately.
      async_reset("async_rst1");

      // Re-acquire from 246 (first sample after release goes to ACQ).
      step("re_d246", 1'b1, 8'd246, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      for (int v = 247; v <= 249; v++)
         step("re_acq", 1'b1, 8'(v), 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      step("re_lock250", 1'b1, 8'd250, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
      for (int v = 251; v <= 255; v++)
         step("pre_wrap", 1'b1, 8'(v), 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
      // 255 -> 0 is a correct increment and counts one wrap.
      step("wrap_d0", 1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd1);
      for (int v = 1; v <= 3; v++)
         step("post_wrap", 1'b1, 8'(v), 1'b1, 1'b0, 1'b0, 8'd0, 8'd1);

      // Mismatch, then reset while err is still high: pulse must be cut off.
      step("mis_d50", 1'b1, 8'd50, 1'b0, 1'b1, !resync, 8'd1, 8'd1);
      #2;
      res = 1'b0;
      #1;
      push("err_cutoff", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      pop_compare();
      @(negedge clk);
      en  = 1'b0;
      res = 1'b1;
      step("after_cut", 1'b1, 8'd9, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);

      check("scoreboard_drained", 8'(sb.size()), 8'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/counter_checker.md
COUNTER_CHECKER -- requirements
Module: counter_checker

Interface
REQ-001 SHALL have parameter: LOCK_N, 4, consecutive correct increments needed to enter LOCKED (legal range 1..15).
REQ-002 SHALL have port: clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port: res  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: en  input  1  sample qualifier; din is evaluated only on cycles with en=1.
REQ-005 SHALL have port: din  input  8  count value driven by an 8-bit free-running up-counter.
REQ-006 SHALL have port: locked  output  1  high while state is LOCKED.
REQ-007 SHALL have port: err  output  1  one-cycle pulse on a sequence mismatch detected in LOCKED.
REQ-008 SHALL have port: fault  output  1  high while state is FAULT.
REQ-009 SHALL have port: err_cnt  output  8  count of detected mismatches, saturating at 255.
REQ-010 SHALL have port: wrap_cnt  output  8  count of correct 255->0 wrap-arounds seen in LOCKED, saturating at 255.

Function
REQ-011 SHALL implement states IDLE, ACQ, LOCKED, FAULT, and SHALL hold an 8-bit expected value exp and a 4-bit good-run counter good.
REQ-012 SHALL leave state, exp, good, err_cnt and wrap_cnt unchanged, and drive err=0, on every cycle with en=0.
REQ-013 IDLE, en=1: SHALL set exp=din+1 (mod 256), set good=0, and go to ACQ.
REQ-014 ACQ, en=1, din==exp: SHALL increment good; when good reaches LOCK_N, SHALL go to LOCKED and clear good.
REQ-015 ACQ, en=1, din!=exp: SHALL clear good, stay in ACQ, and SHALL NOT pulse err or change err_cnt.
REQ-016 In all non-IDLE states, on every en=1 cycle, SHALL set exp=din+1 (mod 256) so that the checker re-aligns to the observed value.
REQ-017 LOCKED, en=1, din==exp: SHALL stay in LOCKED; when din==0, SHALL increment wrap_cnt unless it is at 255.
REQ-018 LOCKED, en=1, din!=exp: SHALL assert err in the next cycle for exactly one cycle, increment err_cnt unless it is at 255, and leave LOCKED (destination per REQ-025/026).
REQ-019 FAULT: SHALL ignore din for error and wrap accounting; err_cnt and wrap_cnt SHALL hold.
REQ-020 All outputs SHALL be registered; locked and fault SHALL update in the same cycle as the state register; latency from a mismatching sample edge to err=1 SHALL be one clock.
REQ-021 Arithmetic on exp SHALL be modulo 256, so din=255 followed by din=0 is a correct increment.

Reset
REQ-022 res=0 SHALL asynchronously force state=IDLE, exp=0, good=0, and drive locked=0, err=0, fault=0, err_cnt=0, wrap_cnt=0.
REQ-023 After res returns to 1, the first rising clk edge with en=1 SHALL be handled per REQ-013.
REQ-024 Asserting res mid-operation, including in LOCKED or FAULT, SHALL discard all history, and any err pulse in progress SHALL be cut off.

Configuration
REQ-025 With macro COUNTER_CHK_RESYNC_EN undefined, a mismatch in LOCKED SHALL go to FAULT, and FAULT SHALL be left only by reset.
REQ-026 With COUNTER_CHK_RESYNC_EN defined, a mismatch in LOCKED SHALL go to ACQ with good=0 and exp=din+1, FAULT SHALL be unreachable, and fault SHALL be tied to 0.

Verification
REQ-027 Reset release followed by din=0,1,2,3,4 with en=1 on every cycle, LOCK_N=4 -> locked=1 after the sample din=4; err=0 and err_cnt=0 throughout.
REQ-028 Locked on a continuous sequence from 250 through 255 to 3 -> wrap_cnt=1; err never asserted.
REQ-029 Locked with din=10,11,20,21 (macro undefined) -> err is high for exactly one cycle after din=20; err_cnt=1, fault=1, locked=0; later samples leave err_cnt at 1.
REQ-030 Same stimulus with COUNTER_CHK_RESYNC_EN defined -> err_cnt=1, fault=0, state is ACQ; locked=1 again after din=21,22,23,24.
REQ-031 Locked, en toggling 1,0,1 with din=5 (en=1), 99 (en=0), 6 (en=1) -> no err; state remains LOCKED.
REQ-032 res pulsed low asynchronously between clock edges while locked and err_cnt=3 -> all outputs 0 immediately; the first sample after release re-enters ACQ.
